// File: rtl/wr_ptr_full.sv
// Write-domain pointer and full-flag generator for the asynchronous FIFO.
// Keeps the binary and Gray write pointers, the write address, an occupancy
// estimate and the full / almost-full / overflow flags. The Gray pointer is a
// direct flop output so the read domain can safely synchronize it.
//
// Handshake: a write is accepted on a rising clk edge when wen is high;
// wen = winc & ~wfull & ~rst. A winc while wfull is high is dropped and
// recorded in the sticky woverflow flag.
module wr_ptr_full #(
    parameter int N_BITS       = 8,
    parameter int AFULL_MARGIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [N_BITS:0]   rptr_sync,
    output logic              wen,
    output logic [N_BITS-1:0] waddr,
    output logic [N_BITS:0]   wptr,
    output logic              wfull,
    output logic              walmost_full,
    output logic [N_BITS:0]   wcount,
    output logic              woverflow
);

    // Almost-full threshold, expressed at pointer width.
    localparam int              AFULL_TH_I = (1 << N_BITS) - AFULL_MARGIN;
    localparam logic [N_BITS:0] AFULL_TH   = AFULL_TH_I[N_BITS:0];

    logic [N_BITS:0] wbin_q, wbin_d;
    logic [N_BITS:0] wptr_q, wptr_d;
    logic            wfull_q, wfull_d;
    logic            walmost_full_q, walmost_full_d;
    logic [N_BITS:0] wcount_q, wcount_d;
    logic            woverflow_q, woverflow_d;

    logic [N_BITS:0] rbin;
    logic [N_BITS:0] full_pattern;
    logic [N_BITS:0] occ_next;

    // Qualified write strobe; forced low during reset.
    assign wen = winc & ~wfull_q & ~rst;

    // Convert the synchronized Gray read pointer to binary (XOR prefix from MSB).
    always_comb begin
        rbin         = '0;
        rbin[N_BITS] = rptr_sync[N_BITS];
        for (int i = N_BITS - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rptr_sync[i];
        end
    end

    // Next-state pointer, flags and occupancy, all from the same wbin_d/rptr_sync.
    always_comb begin
        wbin_d         = wbin_q + {{N_BITS{1'b0}}, wen};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        // Full when the write pointer is one lap ahead: top two Gray bits inverted.
        full_pattern   = {~rptr_sync[N_BITS:N_BITS-1], rptr_sync[N_BITS-2:0]};
        wfull_d        = (wptr_d == full_pattern);
        occ_next       = wbin_d - rbin;
        wcount_d       = occ_next;
        walmost_full_d = (occ_next >= AFULL_TH);
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    // State registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wcount_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wcount_q       <= wcount_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[N_BITS-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wcount       = wcount_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wr_ptr_full.sv
// Self-checking bench for wr_ptr_full with N_BITS=3, AFULL_MARGIN=4.
// The reference model tracks total accepted writes and the read position as
// plain integers and derives every expected output from their difference.
module tb_wr_ptr_full;

    localparam int NB    = 3;
    localparam int DEPTH = 8;
    localparam int MOD   = 16;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          winc = 1'b0;
    logic [NB:0]   rptr_sync = '0;
    logic          wen;
    logic [NB-1:0] waddr;
    logic [NB:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [NB:0]   wcount;
    logic          woverflow;

    int total = 0;
    int bad   = 0;

    // model state
    int m_wr  = 0;  // accepted writes mod 16
    int m_rd  = 0;  // read position mod 16
    bit m_full = 0;
    bit m_af   = 0;
    bit m_ovf  = 0;
    int m_occ  = 0;

    wr_ptr_full #(.N_BITS(NB), .AFULL_MARGIN(AFM)) dut (
        .clk(clk), .rst(rst), .winc(winc), .rptr_sync(rptr_sync),
        .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wcount(wcount), .woverflow(woverflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [NB:0] to_gray(input int b);
        logic [NB:0] v;
        v = b[NB:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".waddr"}, waddr, m_wr % DEPTH);
        check({tag, ".wptr"}, wptr, to_gray(m_wr));
        check({tag, ".wfull"}, wfull, m_full);
        check({tag, ".wcount"}, wcount, m_occ);
        check({tag, ".walmost_full"}, walmost_full, m_af);
        check({tag, ".woverflow"}, woverflow, m_ovf);
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_full = 0; m_af = 0; m_ovf = 0; m_occ = 0;
    endtask

    // Driver: one clock with given write request and read position.
    task automatic cycle(input bit w, input int rd, input string tag);
        bit acc;
        @(negedge clk);
        winc      = w;
        m_rd      = rd % MOD;
        rptr_sync = to_gray(m_rd);
        #1;
        check({tag, ".wen"}, wen, w & ~m_full);
        @(posedge clk);
        acc    = w & ~m_full;
        m_ovf  = m_ovf | (w & m_full);
        m_wr   = (m_wr + acc) % MOD;
        m_occ  = (m_wr - m_rd + MOD) % MOD;
        m_full = (m_occ == DEPTH);
        m_af   = (m_occ >= DEPTH - AFM);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [NB:0] prev;
        int          n;

        // reset state
        #12;
        check_all("rst_init");
        check("rst_init.wen", wen, 0);
        @(negedge clk);
        rst = 1'b0;

        // a few writes, then asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) cycle(1, 0, "pre");
        @(negedge clk);
        winc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        check("rst_async.wen", wen, 0);
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        winc = 1'b0;

        // fill
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 0, "fill");
            if (i == 3) check("fill.af_before4", walmost_full, 0);
            if (i == 4) check("fill.af_at4", walmost_full, 1);
        end
        check("fill.wfull", wfull, 1);
        check("fill.wcount", wcount, 8);
        check("fill.wptr", wptr, 4'b1100);
        check("fill.waddr", waddr, 0);

        // overflow
        for (int i = 0; i < 3; i++) cycle(1, 0, "ovf");
        check("ovf.wptr", wptr, 4'b1100);
        check("ovf.woverflow", woverflow, 1);

        // drain
        cycle(0, 2, "drain");
        check("drain.wfull", wfull, 0);
        check("drain.wcount", wcount, 6);
        check("drain.af", walmost_full, 1);
        cycle(1, 2, "drain_wr");
        check("drain_wr.wcount", wcount, 7);
        check("drain_wr.woverflow", woverflow, 1);

        // wrap-around stream with randomly advancing reader
        prev = wptr;
        n = 0;
        while (n < 40) begin
            int rd;
            bit w;
            rd = m_rd;
            if (((m_wr - m_rd + MOD) % MOD) > 0 && $urandom_range(0, 2) != 0) rd = m_rd + 1;
            w = ($urandom_range(0, 4) != 0);
            if (w && !m_full) n++;
            cycle(w, rd, "wrap");
            if (wptr != prev) check("wrap.gray_step", $countones(wptr ^ prev), 1);
            prev = wptr;
        end

        // simultaneous write and read advance at wcount=5
        while (m_occ != 5) begin
            if (m_occ > 5) cycle(0, m_rd + 1, "to5");
            else cycle(1, m_rd, "to5");
        end
        prev = wptr;
        cycle(1, m_rd + 1, "simul");
        check("simul.wcount", wcount, 5);
        check("simul.wptr_step", $countones(wptr ^ prev), 1);

        // random soak
        for (int i = 0; i < 200; i++) begin
            int rd;
            rd = m_rd;
            if (((m_wr - m_rd + MOD) % MOD) > 0 && $urandom_range(0, 1) == 1)
                rd = m_rd + $urandom_range(1, (m_wr - m_rd + MOD) % MOD);
            prev = wptr;
            cycle($urandom_range(0, 1), rd, "rand");
            if (wptr != prev) check("rand.gray_step", $countones(wptr ^ prev), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
